// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - multi-channel PDM to PCM CIC decimator (ORDER integrators, ORDER combs)
// All channels share one frame counter; pcm_clk is the counter MSB so pcm updates on its falling edge.
module pdm_cic_decimator #(
  parameter int CHANNELS   = 2,
  parameter int DECIMATION = 64,
  parameter int ORDER      = 3,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                            pdm_clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [CHANNELS-1:0]             pdm,
  output logic [CHANNELS*OUT_WIDTH-1:0]   pcm,
  output logic                            pcm_valid,
  output logic                            pcm_clk
);

  localparam int CNT_W  = $clog2(DECIMATION);
  localparam int ACC_W  = ORDER * CNT_W + 2;
  localparam int SHIFT  = ACC_W - OUT_WIDTH;
  localparam int WARM_W = $clog2(ORDER + 1);

  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(DECIMATION - 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);
  localparam logic [ACC_W-1:0]  ONE       = ACC_W'(1);
  localparam logic [ACC_W-1:0]  NEG_ONE   = '1;

  logic [CNT_W-1:0]  cnt;
  logic [WARM_W-1:0] warm;

  logic [CHANNELS-1:0][ORDER-1:0][ACC_W-1:0] integ;
  logic [CHANNELS-1:0][ORDER-1:0][ACC_W-1:0] integ_nxt;
  logic [CHANNELS-1:0][ORDER-1:0][ACC_W-1:0] dly;
  // stage[c][0] is the newest last-integrator value, stage[c][ORDER] the comb output
  logic [CHANNELS-1:0][ORDER:0][ACC_W-1:0]   stage;
  logic [CHANNELS*OUT_WIDTH-1:0]             pcm_nxt;

  always_comb begin
    integ_nxt = '0;
    stage     = '0;
    pcm_nxt   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      integ_nxt[c][0] = integ[c][0] + (pdm[c] ? ONE : NEG_ONE);
      for (int k = 1; k < ORDER; k++) begin
        integ_nxt[c][k] = integ[c][k] + integ_nxt[c][k-1];
      end
      stage[c][0] = integ_nxt[c][ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        stage[c][k+1] = stage[c][k] - dly[c][k];
      end
      pcm_nxt[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(stage[c][ORDER]) >>> SHIFT);
    end
  end

  always_ff @(posedge pdm_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      warm      <= '0;
      integ     <= '0;
      dly       <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else if (!enable) begin
      // flush: a partial frame is dropped and warm-up restarts on the next enable
      cnt       <= '0;
      warm      <= '0;
      integ     <= '0;
      dly       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      integ     <= integ_nxt;
      cnt       <= cnt + CNT_W'(1);
      pcm_valid <= 1'b0;
      if (cnt == LAST) begin
        for (int c = 0; c < CHANNELS; c++) begin
          dly[c] <= stage[c][ORDER-1:0];
        end
        if (warm == WARM_DONE) begin
          pcm       <= pcm_nxt;
          pcm_valid <= 1'b1;
        end else begin
          warm <= warm + WARM_W'(1);
        end
      end
    end
  end

  assign pcm_clk = cnt[CNT_W-1] & enable;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - scoreboard bench for pdm_cic_decimator
// Reference: each frame output is the PDM history convolved with a length-D boxcar raised to ORDER.
module tb_pdm_cic_decimator;

  localparam int CH = 2;
  localparam int D  = 64;
  localparam int N  = 3;
  localparam int OW = 16;
  localparam int SH = N * 6 + 2 - OW;

  logic                pdm_clk = 1'b0;
  logic                reset_n;
  logic                enable;
  logic [CH-1:0]       pdm;
  logic [CH*OW-1:0]    pcm;
  logic                pcm_valid;
  logic                pcm_clk;

  logic                rst2_n;
  logic                en2;
  logic [0:0]          pdm2;
  logic [9:0]          pcm2;
  logic                v2;
  logic                pclk2;

  int checks = 0;
  int errors = 0;

  int               h[$];
  int               hist[CH][$];
  int               cnt_m;
  int               warm_m;
  logic [CH*OW-1:0] exp_q[$];
  logic             exp_pclk;
  logic [CH*OW-1:0] last_pcm;
  bit               mon_en;
  bit               small_done;

  always #5 pdm_clk = ~pdm_clk;

  pdm_cic_decimator #(.CHANNELS(CH), .DECIMATION(D), .ORDER(N), .OUT_WIDTH(OW)) u_dut (
    .pdm_clk   (pdm_clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pdm       (pdm),
    .pcm       (pcm),
    .pcm_valid (pcm_valid),
    .pcm_clk   (pcm_clk)
  );

  pdm_cic_decimator #(.CHANNELS(1), .DECIMATION(16), .ORDER(2), .OUT_WIDTH(10)) u_small (
    .pdm_clk   (pdm_clk),
    .reset_n   (rst2_n),
    .enable    (en2),
    .pdm       (pdm2),
    .pcm       (pcm2),
    .pcm_valid (v2),
    .pcm_clk   (pclk2)
  );

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) hist[c].delete();
    cnt_m  = 0;
    warm_m = 0;
  endfunction

  function automatic void build_kernel();
    int box[$];
    int nh[$];
    h.delete();
    h.push_back(1);
    for (int i = 0; i < D; i++) box.push_back(1);
    for (int s = 0; s < N; s++) begin
      nh.delete();
      for (int i = 0; i < h.size() + D - 1; i++) nh.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < D; j++) nh[i+j] += h[i] * box[j];
      h = nh;
    end
  endfunction

  task automatic drive(input logic en_v, input logic [CH-1:0] bits);
    logic [CH*OW-1:0] e;
    int acc;
    int s;
    int len;
    @(negedge pdm_clk);
    enable = en_v;
    pdm    = bits;
    if (!reset_n || !en_v) begin
      model_clear();
    end else begin
      for (int c = 0; c < CH; c++) begin
        hist[c].push_back(bits[c] ? 1 : -1);
        if (hist[c].size() > h.size()) void'(hist[c].pop_front());
      end
      if (cnt_m == D - 1) begin
        if (warm_m == N) begin
          e = '0;
          for (int c = 0; c < CH; c++) begin
            acc = 0;
            len = hist[c].size();
            for (int j = 0; j < len; j++) acc += h[j] * hist[c][len-1-j];
            s = acc >>> SH;
            e[c*OW +: OW] = s[OW-1:0];
          end
          exp_q.push_back(e);
        end else begin
          warm_m++;
        end
      end
      cnt_m = (cnt_m + 1) % D;
    end
    exp_pclk = en_v && reset_n && (cnt_m >= D / 2);
  endtask

  // monitor: valid must appear exactly when the scoreboard holds an entry
  initial begin
    logic [CH*OW-1:0] e;
    bit               have;
    forever begin
      @(posedge pdm_clk);
      #1;
      if (mon_en && reset_n) begin
        have = (exp_q.size() != 0);
        e    = have ? exp_q.pop_front() : '0;
        chk("pcm_valid", pcm_valid == have, 64'(pcm_valid), 64'(have));
        if (pcm_valid && have) begin
          chk("pcm_value", pcm == e, 64'(pcm), 64'(e));
          last_pcm = pcm;
        end else if (!pcm_valid) begin
          chk("pcm_hold", pcm == last_pcm, 64'(pcm), 64'(last_pcm));
        end
        chk("pcm_clk", pcm_clk == exp_pclk, 64'(pcm_clk), 64'(exp_pclk));
      end
    end
  end

  // reduced configuration: all ones -> +256, 16-cycle 50% pcm_clk
  initial begin
    int  n;
    bit  got;
    int  hi;
    int  rises;
    logic prev;
    rst2_n = 1'b0;
    en2    = 1'b0;
    pdm2   = 1'b1;
    repeat (2) @(negedge pdm_clk);
    rst2_n = 1'b1;
    en2    = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge pdm_clk);
      #1;
      n++;
      if (v2) got = 1'b1;
    end
    chk("small_first_valid_cycle", got && n == 48, 64'(n), 64'd48);
    chk("small_pcm", pcm2 == 10'd256, 64'(pcm2), 64'd256);
    hi    = 0;
    rises = 0;
    prev  = pclk2;
    for (int i = 0; i < 64; i++) begin
      @(posedge pdm_clk);
      #1;
      if (pclk2) hi++;
      if (pclk2 && !prev) rises++;
      if (v2) begin
        chk("small_pcm_repeat", pcm2 == 10'd256, 64'(pcm2), 64'd256);
        chk("small_update_on_fall", prev && !pclk2, 64'({prev, pclk2}), 64'b10);
      end
      prev = pclk2;
    end
    chk("small_pclk_high_count", hi == 32, 64'(hi), 64'd32);
    chk("small_pclk_rises", rises == 4, 64'(rises), 64'd4);
    small_done = 1'b1;
  end

  initial begin
    int guard;
    build_kernel();
    model_clear();
    mon_en     = 1'b0;
    small_done = 1'b0;
    exp_pclk   = 1'b0;
    last_pcm   = '0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    pdm        = '0;
    #12;
    chk("reset_pcm", pcm == '0, 64'(pcm), 64'd0);
    chk("reset_valid", pcm_valid == 1'b0, 64'(pcm_valid), 64'd0);
    chk("reset_pclk", pcm_clk == 1'b0, 64'(pcm_clk), 64'd0);
    @(posedge pdm_clk);
    #3;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    repeat (6 * D) drive(1'b1, 2'b11);
    repeat (5 * D) drive(1'b1, 2'b00);
    for (int i = 0; i < 5 * D; i++) drive(1'b1, {CH{i[0] == 1'b0}});
    repeat (5 * D) drive(1'b1, 2'b01);
    repeat (6 * D) drive(1'b1, 2'($urandom()));

    guard = 0;
    while (cnt_m != 30 && guard < 2 * D) begin
      drive(1'b1, 2'($urandom()));
      guard++;
    end
    chk("reach_cnt30", cnt_m == 30, 64'(cnt_m), 64'd30);
    repeat (10) drive(1'b0, 2'($urandom()));
    repeat (6 * D) drive(1'b1, 2'($urandom()));

    repeat (5 * D) drive(1'b1, 2'b11);
    guard = 0;
    while (cnt_m != 40 && guard < 2 * D) begin
      drive(1'b1, 2'b11);
      guard++;
    end
    @(posedge pdm_clk);
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pcm", pcm == '0, 64'(pcm), 64'd0);
    chk("async_reset_valid", pcm_valid == 1'b0, 64'(pcm_valid), 64'd0);
    chk("async_reset_pclk", pcm_clk == 1'b0, 64'(pcm_clk), 64'd0);
    exp_q.delete();
    last_pcm = '0;
    repeat (2) drive(1'b1, 2'b11);
    @(posedge pdm_clk);
    #3;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (5 * D) drive(1'b1, 2'b10);

    guard = 0;
    while (!small_done && guard < 2000) begin
      @(posedge pdm_clk);
      guard++;
    end
    chk("small_done", small_done, 64'(small_done), 64'd1);
    @(posedge pdm_clk);
    #2;
    chk("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of parallel PDM streams (legal range 1..8).
REQ-002 SHALL have parameter DECIMATION, default 64, PDM bits per PCM sample (power of two, 4..256).
REQ-003 SHALL have parameter ORDER, default 3, number of CIC integrator/comb stages (1..5).
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed PCM width per channel (legal range 8..ACC_W).
REQ-005 SHALL define the derived constant ACC_W = ORDER*log2(DECIMATION)+2, the integrator and comb width.
REQ-006 SHALL have port pdm_clk, input, 1 bit: the only clock; all logic is posedge pdm_clk.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: synchronous run/flush control.
REQ-009 SHALL have port pdm, input, CHANNELS bits: bit c is the PDM bit of channel c, sampled every pdm_clk.
REQ-010 SHALL have port pcm, output, CHANNELS*OUT_WIDTH bits: channel c occupies bits [c*OUT_WIDTH +: OUT_WIDTH], two's complement.
REQ-011 SHALL have port pcm_valid, output, 1 bit: one-cycle strobe marking new pcm.
REQ-012 SHALL have port pcm_clk, output, 1 bit: frame-rate clock for downstream I2S/codec logic.

Function
REQ-013 SHALL map each pdm bit to +1 (1) or -1 (0) before the first integrator.
REQ-014 SHALL update ORDER cascaded ACC_W-bit integrators per channel every enabled cycle, using modular (wrapping) arithmetic; wrap is intended and is not an error.
REQ-015 SHALL keep a frame counter 0..DECIMATION-1 that increments every enabled cycle and wraps from DECIMATION-1 to 0.
REQ-016 SHALL, in the cycle the counter equals DECIMATION-1, feed the last integrator output (including that cycle's sample) through ORDER cascaded differential-delay-1 combs, with modular ACC_W-bit arithmetic.
REQ-017 SHALL register the comb result to pcm, and assert pcm_valid for exactly one cycle, in the cycle after the counter equals DECIMATION-1 (latency: 1 cycle after the frame's last PDM bit).
REQ-018 SHALL scale the comb result to OUT_WIDTH by arithmetic right shift of (ACC_W-OUT_WIDTH), truncating toward negative infinity; full-scale +/-DECIMATION^ORDER maps to +/-2^(OUT_WIDTH-2).
REQ-019 SHALL process all channels in lockstep on the same frame counter, with identical latency.
REQ-020 SHALL suppress pcm_valid and leave pcm unchanged for the first ORDER frames after reset release or enable rising (comb warm-up); frame ORDER+1 is the first valid output.
REQ-021 SHALL drive pcm_clk low while the counter is 0..DECIMATION/2-1 and high while it is DECIMATION/2..DECIMATION-1; the registered pcm update coincides with pcm_clk falling.
REQ-022 SHALL, while enable is low, hold the counter at 0, clear all integrators, comb delays and the warm-up count, force pcm_valid and pcm_clk low, and hold pcm.
REQ-023 SHALL, if enable falls mid-frame, discard the partial frame without emitting pcm_valid.
REQ-024 SHALL start a frame at counter 0 in the first cycle with enable high after enable was low.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear the counter, integrators, comb delays, warm-up count, pcm (all zeros), pcm_valid (0) and pcm_clk (0).
REQ-026 SHALL resume operation on the first pdm_clk edge after reset_n deasserts with enable high, beginning a frame at counter 0.
REQ-027 SHALL, when reset is asserted mid-frame, emit no pcm_valid for that frame.

Verification
REQ-028 SHALL be verified with defaults and pdm constant 1 on all channels -> first pcm_valid after 4 frames (256+1 cycles), every channel = +16384, valid pulse every 64 cycles.
REQ-029 SHALL be verified with defaults and pdm constant 0 -> every channel = -16384 after warm-up.
REQ-030 SHALL be verified with defaults and pdm alternating 1,0 -> pcm = 0 on every post-warm-up frame; with channel 0 all ones and channel 1 all zeros -> +16384 and -16384 respectively in the same strobe.
REQ-031 SHALL be verified with enable dropped at counter 30 for 10 cycles -> no pcm_valid for the broken frame, 3-frame warm-up restarts, pcm holds its prior value throughout.
REQ-032 SHALL be verified with reset_n asserted asynchronously mid-frame -> pcm, pcm_valid and pcm_clk go to 0 immediately, without waiting for a pdm_clk edge.
REQ-033 SHALL be verified with CHANNELS=1, DECIMATION=16, ORDER=2, OUT_WIDTH=10 and all-ones input -> pcm = +256, pcm_clk period 16 cycles with 50% duty.
